// File: rtl/counter_pkg.sv
// Shared definitions for the programmable modulo counter family.
// Holds the direction and mode encodings and the load-clamp helper.
package counter_pkg;

  localparam logic CNT_UP       = 1'b1;
  localparam logic CNT_DOWN     = 1'b0;
  localparam logic MODE_FREE    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  localparam int unsigned CntWMax = 32;

  // Operands are zero-extended to CntWMax so one helper serves every counter width.
  function automatic logic [CntWMax-1:0] clamp_load(input logic [CntWMax-1:0] val,
                                                     input logic [CntWMax-1:0] last);
    return (val > last) ? last : val;
  endfunction

endpackage

// File: rtl/mod_m_counter_prog_if.sv
// Control and status bundle of the programmable modulo counter.
// The master drives the controls and the slave (the counter) returns its status.
interface mod_m_counter_prog_if #(
  parameter int unsigned N = 4
);
  logic         en;
  logic         up;
  logic         load;
  logic [N-1:0] load_val;
  logic         last_wr;
  logic [N-1:0] last_in;
  logic         oneshot;
  logic [N-1:0] q;
  logic [N-1:0] last_q;
  logic         max_tick;
  logic         min_tick;
  logic         carry;
  logic         done;

  modport master (
    output en, up, load, load_val, last_wr, last_in, oneshot,
    input  q, last_q, max_tick, min_tick, carry, done
  );

  modport slave (
    input  en, up, load, load_val, last_wr, last_in, oneshot,
    output q, last_q, max_tick, min_tick, carry, done
  );
endinterface

// File: rtl/mod_term_detect.sv
// Terminal-condition compare for modulo counters. The inequalities let a counter
// recover when its terminal value is lowered below the current count.
module mod_term_detect
  import counter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] last_q_i,
  input  logic         up_i,
  output logic         term_o
);

  always_comb begin
    term_o = 1'b0;
    if (up_i == CNT_UP) begin
      term_o = (q_i >= last_q_i);
    end else begin
      term_o = (q_i == '0) || (q_i > last_q_i);
    end
  end

endmodule

// File: rtl/mod_m_counter_prog.sv
// Runtime-programmable modulo counter with load, direction, one-shot mode and a
// qualified carry that feeds the next stage's enable.
module mod_m_counter_prog
  import counter_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned M = 10
) (
  input  logic                clk,
  input  logic                reset,
  mod_m_counter_prog_if.slave bus
);

  localparam logic [N-1:0] LastRst = N'(M - 1);
  localparam logic [N-1:0] One     = N'(1);

  logic [N-1:0] q_q, q_d;
  logic [N-1:0] last_q_q, last_q_d;
  logic         halted_q, halted_d;
  logic         term;
  logic [N-1:0] load_clamped;

  mod_term_detect #(
    .N (N)
  ) u_term (
    .q_i      (q_q),
    .last_q_i (last_q_q),
    .up_i     (bus.up),
    .term_o   (term)
  );

  // Clamp and step both use the terminal value from before any same-cycle write.
  assign load_clamped = N'(clamp_load(CntWMax'(bus.load_val), CntWMax'(last_q_q)));

  always_comb begin
    q_d      = q_q;
    last_q_d = last_q_q;
    halted_d = halted_q;
    if (reset) begin
      q_d      = '0;
      last_q_d = LastRst;
      halted_d = 1'b0;
    end else begin
      if (bus.last_wr) begin
        last_q_d = bus.last_in;
      end
      if (bus.load) begin
        q_d      = load_clamped;
        halted_d = 1'b0;
      end else if (bus.en && !halted_q) begin
        if (term && bus.oneshot == MODE_ONESHOT) begin
          q_d      = (bus.up == CNT_UP) ? last_q_q : '0;
          halted_d = 1'b1;
        end else if (term) begin
          q_d = (bus.up == CNT_UP) ? '0 : last_q_q;
        end else begin
          q_d = (bus.up == CNT_UP) ? q_q + One : q_q - One;
        end
      end
      if (bus.oneshot == MODE_FREE) begin
        halted_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    q_q      <= q_d;
    last_q_q <= last_q_d;
    halted_q <= halted_d;
  end

  assign bus.q        = q_q;
  assign bus.last_q   = last_q_q;
  assign bus.max_tick = (q_q == last_q_q);
  assign bus.min_tick = (q_q == '0);
  assign bus.carry    = bus.en & ~bus.load & ~reset & term & ~halted_q;
  assign bus.done     = halted_q;

endmodule

// File: tb/tb_mod_m_counter_prog.sv
// Directed bench for mod_m_counter_prog: one standalone counter plus a two-stage
// cascade, with hand-computed expectations checked by immediate assertions.
module tb_mod_m_counter_prog;

  logic clk = 1'b0;
  logic reset;
  logic rst_c;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mod_m_counter_prog_if #(.N(4)) a_if ();
  mod_m_counter_prog_if #(.N(4)) b_if ();
  mod_m_counter_prog_if #(.N(4)) c_if ();

  mod_m_counter_prog #(.N(4), .M(10)) u_dut (.clk(clk), .reset(reset), .bus(a_if));
  mod_m_counter_prog #(.N(4), .M(10)) u_lo  (.clk(clk), .reset(rst_c), .bus(b_if));
  mod_m_counter_prog #(.N(4), .M(10)) u_hi  (.clk(clk), .reset(rst_c), .bus(c_if));

  assign c_if.en = b_if.carry;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    rst_c = 1'b1;
    a_if.en = 1'b0; a_if.up = 1'b1; a_if.load = 1'b0; a_if.load_val = '0;
    a_if.last_wr = 1'b0; a_if.last_in = '0; a_if.oneshot = 1'b0;
    b_if.en = 1'b1; b_if.up = 1'b1; b_if.load = 1'b0; b_if.load_val = '0;
    b_if.last_wr = 1'b0; b_if.last_in = '0; b_if.oneshot = 1'b0;
    c_if.up = 1'b1; c_if.load = 1'b0; c_if.load_val = '0;
    c_if.last_wr = 1'b0; c_if.last_in = '0; c_if.oneshot = 1'b0;
    step();
    chk4("rst_q", a_if.q, 4'd0);
    chk4("rst_last", a_if.last_q, 4'd9);
    chk1("rst_done", a_if.done, 1'b0);
    chk1("rst_min", a_if.min_tick, 1'b1);
    chk1("rst_max", a_if.max_tick, 1'b0);

    // Free-run up through one full period
    reset = 1'b0; a_if.en = 1'b1; a_if.up = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk4("up_q", a_if.q, 4'(i));
      chk1("up_max", a_if.max_tick, i == 9);
      chk1("up_carry", a_if.carry, i == 9);
      step();
    end
    chk4("up_wrap", a_if.q, 4'd0);

    // Down count wraps from 0 to the terminal value
    a_if.up = 1'b0;
    #1;
    chk1("dn_min", a_if.min_tick, 1'b1);
    chk1("dn_carry", a_if.carry, 1'b1);
    step();
    chk4("dn_q9", a_if.q, 4'd9);
    chk1("dn_carry0", a_if.carry, 1'b0);
    step();
    chk4("dn_q8", a_if.q, 4'd8);

    // Terminal write to 5 while at 3
    a_if.load = 1'b1; a_if.load_val = 4'd3;
    step();
    a_if.load = 1'b0; a_if.up = 1'b1; a_if.last_wr = 1'b1; a_if.last_in = 4'd5;
    step();
    chk4("tw_q4", a_if.q, 4'd4);
    chk4("tw_last5", a_if.last_q, 4'd5);
    a_if.last_wr = 1'b0;
    step();
    chk4("tw_q5", a_if.q, 4'd5);
    chk1("tw_max", a_if.max_tick, 1'b1);
    chk1("tw_carry", a_if.carry, 1'b1);
    step();
    chk4("tw_q0", a_if.q, 4'd0);

    // Load with same-cycle terminal write clamps against the old terminal
    a_if.load = 1'b1; a_if.load_val = 4'd7; a_if.last_wr = 1'b1; a_if.last_in = 4'd9;
    step();
    chk4("sim_ld_q", a_if.q, 4'd5);
    chk4("sim_ld_last", a_if.last_q, 4'd9);
    a_if.last_wr = 1'b0;
    step();
    chk4("ld7_q", a_if.q, 4'd7);

    // Lower terminal below q, next up step wraps to 0
    a_if.load = 1'b0; a_if.en = 1'b0; a_if.last_wr = 1'b1; a_if.last_in = 4'd2;
    step();
    chk4("low_last", a_if.last_q, 4'd2);
    chk4("low_hold", a_if.q, 4'd7);
    a_if.last_wr = 1'b0; a_if.en = 1'b1;
    #1;
    chk1("low_carry", a_if.carry, 1'b1);
    step();
    chk4("low_q0", a_if.q, 4'd0);

    // Clamp of an out-of-range load
    a_if.en = 1'b0; a_if.last_wr = 1'b1; a_if.last_in = 4'd5;
    step();
    a_if.last_wr = 1'b0; a_if.load = 1'b1; a_if.load_val = 4'd12;
    step();
    chk4("clamp_q", a_if.q, 4'd5);

    // Wrap step with same-cycle terminal write uses the old terminal
    a_if.load = 1'b0; a_if.en = 1'b1; a_if.last_wr = 1'b1; a_if.last_in = 4'd9;
    #1;
    chk1("sim_wr_carry", a_if.carry, 1'b1);
    step();
    chk4("sim_wr_q", a_if.q, 4'd0);
    chk4("sim_wr_last", a_if.last_q, 4'd9);
    a_if.last_wr = 1'b0;

    // One-shot up to terminal 3
    a_if.en = 1'b0; a_if.last_wr = 1'b1; a_if.last_in = 4'd3;
    a_if.load = 1'b1; a_if.load_val = 4'd0; a_if.oneshot = 1'b1;
    step();
    a_if.last_wr = 1'b0; a_if.load = 1'b0; a_if.en = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk4("os_q", a_if.q, 4'(i));
      chk1("os_carry", a_if.carry, 1'b0);
      chk1("os_done", a_if.done, 1'b0);
      step();
    end
    chk4("os_q3", a_if.q, 4'd3);
    chk1("os_carry3", a_if.carry, 1'b1);
    chk1("os_done3", a_if.done, 1'b0);
    step();
    chk4("os_hold", a_if.q, 4'd3);
    chk1("os_done_set", a_if.done, 1'b1);
    chk1("os_carry_once", a_if.carry, 1'b0);
    step();
    chk4("os_hold2", a_if.q, 4'd3);
    chk1("os_done2", a_if.done, 1'b1);
    a_if.load = 1'b1; a_if.load_val = 4'd0;
    #1;
    chk1("os_ld_carry", a_if.carry, 1'b0);
    step();
    chk4("os_ld_q", a_if.q, 4'd0);
    chk1("os_ld_done", a_if.done, 1'b0);
    a_if.load = 1'b0;
    step();
    chk4("os_resume", a_if.q, 4'd1);

    // Load beats en at the terminal, suppressing carry
    a_if.oneshot = 1'b0;
    step();
    step();
    chk4("pri_q3", a_if.q, 4'd3);
    a_if.load = 1'b1; a_if.load_val = 4'd1;
    #1;
    chk1("pri_carry", a_if.carry, 1'b0);
    step();
    chk4("pri_q", a_if.q, 4'd1);
    a_if.load = 1'b0;

    // Terminal 0: count stuck at 0 with carry following en
    a_if.en = 1'b0; a_if.last_wr = 1'b1; a_if.last_in = 4'd0;
    step();
    a_if.last_wr = 1'b0; a_if.en = 1'b1;
    #1;
    chk1("z_carry_a", a_if.carry, 1'b1);
    step();
    chk4("z_q0", a_if.q, 4'd0);
    chk1("z_carry_b", a_if.carry, 1'b1);
    step();
    chk4("z_q0b", a_if.q, 4'd0);
    a_if.en = 1'b0;
    #1;
    chk1("z_carry_off", a_if.carry, 1'b0);

    // Reset at a terminal forces carry low and restores defaults
    a_if.en = 1'b1; reset = 1'b1;
    #1;
    chk1("rst_carry", a_if.carry, 1'b0);
    step();
    chk4("rst2_q", a_if.q, 4'd0);
    chk4("rst2_last", a_if.last_q, 4'd9);
    reset = 1'b0;

    // Reset clears done
    a_if.oneshot = 1'b1; a_if.load = 1'b1; a_if.load_val = 4'd9;
    step();
    a_if.load = 1'b0;
    #1;
    chk1("rd_carry", a_if.carry, 1'b1);
    step();
    chk1("rd_done1", a_if.done, 1'b1);
    reset = 1'b1;
    step();
    chk1("rd_done0", a_if.done, 1'b0);
    chk4("rd_q", a_if.q, 4'd0);
    reset = 1'b0; a_if.oneshot = 1'b0; a_if.en = 1'b0;

    // Two-stage cascade counts 00..99 and rolls over
    rst_c = 1'b0;
    #1;
    for (int k = 0; k <= 100; k++) begin
      chk4("cas_lo", b_if.q, 4'(k % 10));
      chk4("cas_hi", c_if.q, 4'((k / 10) % 10));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mod_m_counter_prog.md
# mod_m_counter_prog

Runtime-programmable modulo counter: the successor of the fixed mod-M counter used for baud-rate ticks, prescalers and pipeline stall timers. It adds synchronous reset, count enable, up/down direction, parallel load, a runtime-writable terminal value, a one-shot mode, and a qualified carry output for cascading stages. It sits wherever a divider or timeout counter is needed and chains stage-to-stage through `carry` into `en`.

## Interface
- `N`, default 4: counter width in bits.
- `M`, default 10: reset modulus, with 2 ≤ M ≤ 2^N. Terminal value after reset is M-1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  count enable, one step per cycle while high.
- `up`  in  1  direction: 1 counts up, 0 counts down.
- `load`  in  1  parallel load strobe.
- `load_val`  in  N  value to load.
- `last_wr`  in  1  write strobe for the terminal value.
- `last_in`  in  N  new terminal value (modulus − 1).
- `oneshot`  in  1  1 = stop at terminal, 0 = free-run with wrap.
- `q`  out  N  registered count.
- `last_q`  out  N  current terminal value register.
- `max_tick`  out  1  combinational, `q == last_q`, unqualified (same meaning as the legacy counter).
- `min_tick`  out  1  combinational, `q == 0`.
- `carry`  out  1  combinational, one-cycle cascade/wrap pulse, as defined below.
- `done`  out  1  registered one-shot halted flag.

## Operation
- State consists of three registers: `q`, `last_q` and `halted`.
- Reset values: `q` = 0, `last_q` = M-1, `halted` = 0, so `done` = 0.
- **Update priority for `q`:** `reset` > `load` > `en`. With none of them active, `q` holds.
- **Load:** `q` ← `load_val`, clamped to `last_q` when `load_val` > `last_q`. Load always clears `halted`.
- **Terminal condition `term`:**
  - Up: `q` ≥ `last_q`.
  - Down: `q` == 0, or `q` > `last_q`.
  - Using ≥ and > recovers cleanly after `last_q` is lowered below `q`.
- **Count, free-run (`oneshot` = 0), with `en` = 1 and `load` = 0:**
  - Up: `q` ← 0 if `term`, else `q`+1.
  - Down: `q` ← `last_q` if `term`, else `q`−1.
- **Count, one-shot (`oneshot` = 1):**
  - Not at `term`: step as in free-run.
  - At `term`: hold the value (up: `last_q`; down: 0; an out-of-range `q` is forced to that value) and set `halted`.
  - While `halted` = 1, `en` has no effect.
- **carry** = `en` & ~`load` & ~`reset` & `term` & ~`halted`.
  - Free-run: pulses once per wrap.
  - One-shot: pulses exactly once, on the arrival cycle.
- **Terminal write:** `last_wr` sets `last_q` ← `last_in` at the next edge. Reset overrides `last_wr`.
  - `last_in` = 0 is legal and gives a count stuck at 0 with `carry` = `en`.
- **Simultaneous events:** `last_wr` together with count or load in the same cycle uses the OLD `last_q`, for the step, the wrap and the clamp.
- **Mode switch:** toggling `oneshot` from 1 to 0 while halted resumes counting on the next `en`. `halted` is cleared whenever `oneshot` = 0.
- **Direction change:** takes effect on the same cycle's step. No extra state.
- **Arithmetic:** all comparisons are N-bit unsigned. Increment and decrement are modulo 2^N, but wrap is always governed by `term`, never by overflow.

## Timing
- `q`, `last_q` and `done` are registered: a change appears one cycle after the qualifying edge.
- `max_tick`, `min_tick` and `carry` are combinational from the registers and current inputs, with no added latency. `carry` is valid in the same cycle as the `en` that causes the wrap.
- Cascade rule: the next stage's `en` = this stage's `carry`. Chained stages then wrap on the same edge.
- Reset asserted mid-count takes effect at the next edge. While `reset` is high, `carry` is forced to 0.

## Structure
- Shared package `counter_pkg`:
  - direction constants `CNT_UP` and `CNT_DOWN`;
  - mode constants `MODE_FREE` and `MODE_ONESHOT`;
  - a function returning the clamped load value.
- One sub-module, `mod_term_detect`: a combinational `term` compare taking `q`, `last_q` and `up`. It is reused by future cascaded prescaler blocks.
- The top level holds the three registers and the next-state logic.

## Test plan
- Reset values, then free-run up with M=10 and `en` held 1: `q` runs 0..9,0. `carry` and `max_tick` are high at `q`=9; `carry` pulses every 10 cycles.
- Down count: `up`=0 from `q`=0 wraps to 9, then 8. `min_tick` is high at 0, and `carry` is high on the 0 cycle.
- Terminal write and clamping:
  - `last_in`=5 with `last_wr` while `q`=3: `q` goes 4, 5, 0.
  - Write `last_in`=2 while `q`=7 counting up: next `q` = 0.
  - `load_val`=12 with `last_q`=5 loads 5.
- One-shot up from 0 with `last_q`=3: `q` = 0, 1, 2, 3, 3...; `carry` is high exactly once; `done`=1 from the next cycle. A load of 0 clears `done` and the count resumes.
- Simultaneous: `load`=1 with `en`=1 gives load priority and `carry`=0. `last_wr` with a wrap step wraps on the old terminal value. `reset` mid-count gives `q`=0, `last_q`=9 and `done`=0 on the next edge.
- Cascade of two instances (M=10 each) driven by `en`=1: the upper stage increments only on the lower stage's 9→0 wrap. The combined count reaches 99 and then rolls over to 00.
